// File: rtl/lane_fifo_bank_pkg.sv
// Shared parameters and parameter-legality helper for the four-lane output FIFO bank.
package lane_fifo_bank_pkg;

  localparam int unsigned LANES  = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned AF_TH  = 3;
  localparam int unsigned AE_TH  = 1;

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  // Depth must be a power of two (pointers wrap by overflow) and thresholds ordered.
  function automatic bit params_legal(int unsigned depth, int unsigned af_th,
                                      int unsigned ae_th);
    return (depth >= 2) && ((depth & (depth - 1)) == 0) &&
           (ae_th < af_th) && (af_th <= depth);
  endfunction

endpackage

// File: rtl/lane_fifo_bank_if.sv
// Push/pop/status bundle between the recirculator, the FIFO bank and its consumer.
interface lane_fifo_bank_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] data_in0, data_in1, data_in2, data_in3;
  logic              valid_in0, valid_in1, valid_in2, valid_in3;
  logic              pop0, pop1, pop2, pop3;
  logic [DATA_W-1:0] data_out0, data_out1, data_out2, data_out3;
  logic              valid_out0, valid_out1, valid_out2, valid_out3;
  logic              full0, full1, full2, full3;
  logic              empty0, empty1, empty2, empty3;
  logic              almost_full0, almost_full1, almost_full2, almost_full3;
  logic              almost_empty0, almost_empty1, almost_empty2, almost_empty3;
  logic              pause;
  logic              error;

  modport master (
    output data_in0, data_in1, data_in2, data_in3,
    output valid_in0, valid_in1, valid_in2, valid_in3,
    output pop0, pop1, pop2, pop3,
    input  data_out0, data_out1, data_out2, data_out3,
    input  valid_out0, valid_out1, valid_out2, valid_out3,
    input  full0, full1, full2, full3,
    input  empty0, empty1, empty2, empty3,
    input  almost_full0, almost_full1, almost_full2, almost_full3,
    input  almost_empty0, almost_empty1, almost_empty2, almost_empty3,
    input  pause, error
  );

  modport slave (
    input  data_in0, data_in1, data_in2, data_in3,
    input  valid_in0, valid_in1, valid_in2, valid_in3,
    input  pop0, pop1, pop2, pop3,
    output data_out0, data_out1, data_out2, data_out3,
    output valid_out0, valid_out1, valid_out2, valid_out3,
    output full0, full1, full2, full3,
    output empty0, empty1, empty2, empty3,
    output almost_full0, almost_full1, almost_full2, almost_full3,
    output almost_empty0, almost_empty1, almost_empty2, almost_empty3,
    output pause, error
  );
endinterface

// File: rtl/lane_fifo_bank_lane_fifo.sv
// Single-lane FIFO: registered pop data, count-decoded flags, combinational err pulse.
module lane_fifo
  import lane_fifo_bank_pkg::*;
#(
  parameter int unsigned DATA_W = lane_fifo_bank_pkg::DATA_W,
  parameter int unsigned DEPTH  = lane_fifo_bank_pkg::DEPTH,
  parameter int unsigned AF_TH  = lane_fifo_bank_pkg::AF_TH,
  parameter int unsigned AE_TH  = lane_fifo_bank_pkg::AE_TH
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_almost_full,
  output logic              o_almost_empty,
  output logic              o_err
);

  localparam int unsigned L_PTR_W = $clog2(DEPTH);
  localparam int unsigned L_CNT_W = L_PTR_W + 1;

  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [L_PTR_W-1:0] r_wr_ptr;
  logic [L_PTR_W-1:0] r_rd_ptr;
  logic [L_CNT_W-1:0] r_count;
  logic [DATA_W-1:0]  r_data;
  logic               r_valid;

  logic w_full;
  logic w_empty;
  logic w_pop_ok;
  logic w_push_ok;

  assign w_full    = (r_count == L_CNT_W'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_pop_ok  = i_pop & ~w_empty;
  // A full lane still takes a push when the same cycle frees a slot; empty lanes never bypass.
  assign w_push_ok = i_valid & (~w_full | w_pop_ok);

  // NOTE: storage has no reset; stale words are unreachable because pointers and count reset.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= w_pop_ok;
      if (w_pop_ok) begin
        r_data   <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_push_ok && !w_pop_ok)      r_count <= r_count + 1'b1;
      else if (!w_push_ok && w_pop_ok) r_count <= r_count - 1'b1;
    end
  end

  assign o_data         = r_data;
  assign o_valid        = r_valid;
  assign o_full         = w_full;
  assign o_empty        = w_empty;
  assign o_almost_full  = (r_count >= L_CNT_W'(AF_TH));
  assign o_almost_empty = (r_count <= L_CNT_W'(AE_TH));
  assign o_err          = (i_valid & w_full & ~i_pop) | (i_pop & w_empty);

endmodule

// File: rtl/lane_fifo_bank.sv
// Four independent lane FIFOs behind the recirculator; pause feeds its selector_IDLE.
module lane_fifo_bank
  import lane_fifo_bank_pkg::*;
#(
  parameter int unsigned DATA_W = lane_fifo_bank_pkg::DATA_W,
  parameter int unsigned DEPTH  = lane_fifo_bank_pkg::DEPTH,
  parameter int unsigned AF_TH  = lane_fifo_bank_pkg::AF_TH,
  parameter int unsigned AE_TH  = lane_fifo_bank_pkg::AE_TH
) (
  input  logic             clk,
  input  logic             reset_L,
  lane_fifo_bank_if.slave  bus
);

  if (!params_legal(DEPTH, AF_TH, AE_TH)) begin : g_bad_params
    $error("lane_fifo_bank: need DEPTH power of 2 >= 2 and AE_TH < AF_TH <= DEPTH");
  end

  logic [DATA_W-1:0] w_data_in  [LANES];
  logic [DATA_W-1:0] w_data_out [LANES];
  logic [LANES-1:0]  w_valid_in;
  logic [LANES-1:0]  w_pop;
  logic [LANES-1:0]  w_valid_out;
  logic [LANES-1:0]  w_full;
  logic [LANES-1:0]  w_empty;
  logic [LANES-1:0]  w_almost_full;
  logic [LANES-1:0]  w_almost_empty;
  logic [LANES-1:0]  w_err;
  logic              r_error;

  assign w_data_in[0] = bus.data_in0;
  assign w_data_in[1] = bus.data_in1;
  assign w_data_in[2] = bus.data_in2;
  assign w_data_in[3] = bus.data_in3;
  assign w_valid_in   = {bus.valid_in3, bus.valid_in2, bus.valid_in1, bus.valid_in0};
  assign w_pop        = {bus.pop3, bus.pop2, bus.pop1, bus.pop0};

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    lane_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AF_TH  (AF_TH),
      .AE_TH  (AE_TH)
    ) u_lane (
      .clk            (clk),
      .reset_L        (reset_L),
      .i_data         (w_data_in[g]),
      .i_valid        (w_valid_in[g]),
      .i_pop          (w_pop[g]),
      .o_data         (w_data_out[g]),
      .o_valid        (w_valid_out[g]),
      .o_full         (w_full[g]),
      .o_empty        (w_empty[g]),
      .o_almost_full  (w_almost_full[g]),
      .o_almost_empty (w_almost_empty[g]),
      .o_err          (w_err[g])
    );
  end

  // Any lane's overflow or underflow latches the shared error until reset.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) r_error <= 1'b0;
    else          r_error <= r_error | (|w_err);
  end

  assign bus.data_out0 = w_data_out[0];
  assign bus.data_out1 = w_data_out[1];
  assign bus.data_out2 = w_data_out[2];
  assign bus.data_out3 = w_data_out[3];

  assign {bus.valid_out3, bus.valid_out2, bus.valid_out1, bus.valid_out0} = w_valid_out;
  assign {bus.full3, bus.full2, bus.full1, bus.full0}                     = w_full;
  assign {bus.empty3, bus.empty2, bus.empty1, bus.empty0}                 = w_empty;
  assign {bus.almost_full3, bus.almost_full2,
          bus.almost_full1, bus.almost_full0}                             = w_almost_full;
  assign {bus.almost_empty3, bus.almost_empty2,
          bus.almost_empty1, bus.almost_empty0}                           = w_almost_empty;

  assign bus.pause = |w_almost_full;
  assign bus.error = r_error;

endmodule
